// File: rtl/fpadd_arbiter.sv
// Round-robin arbiter sharing one multi-cycle FP adder between two requesters.
// Optional watchdog on the adder wait is enabled by defining FPADD_TIMEOUT_EN.
module fpadd_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req0_n0,
  input  logic [31:0] req0_n1,
  input  logic [31:0] req1_n0,
  input  logic [31:0] req1_n1,
  output logic [31:0] add_n0,
  output logic [31:0] add_n1,
  output logic        add_go,
  input  logic        add_done,
  input  logic [31:0] add_val,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_val,
  output logic        rsp_err,
  output logic        busy,
  output logic [3:0]  leds
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        gnt_q, gnt_d;
  logic [31:0] add_n0_q, add_n0_d;
  logic [31:0] add_n1_q, add_n1_d;
  logic [31:0] rsp_val_q, rsp_val_d;
  logic        rsp_err_q, rsp_err_d;
  logic        cand;
`ifdef FPADD_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  logic [7:0]  cnt_q, cnt_d;
`endif

  // Grant candidate: sole requester, or the one not served last on contention.
  always_comb begin
    cand = 1'b0;
    case (req_valid)
      2'b10:   cand = 1'b1;
      2'b11:   cand = ~last_q;
      default: cand = 1'b0;
    endcase
    req_ready = '0;
    if (state_q == S_IDLE && !reset && |req_valid) req_ready[cand] = 1'b1;
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    gnt_d     = gnt_q;
    add_n0_d  = add_n0_q;
    add_n1_d  = add_n1_q;
    rsp_val_d = rsp_val_q;
    rsp_err_d = rsp_err_q;
`ifdef FPADD_TIMEOUT_EN
    cnt_d     = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req_ready) begin
          add_n0_d = cand ? req1_n0 : req0_n0;
          add_n1_d = cand ? req1_n1 : req0_n1;
          gnt_d    = cand;
          last_d   = cand;
          state_d  = S_ISSUE;
        end
      end
      S_ISSUE: begin
`ifdef FPADD_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (add_done) begin
          rsp_val_d = add_val;
          rsp_err_d = 1'b0;
          state_d   = S_RESP;
        end
`ifdef FPADD_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          rsp_val_d = 32'h7FC0_0000;
          rsp_err_d = 1'b1;
          state_d   = S_RESP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      last_q    <= 1'b1;
      gnt_q     <= 1'b0;
      add_n0_q  <= '0;
      add_n1_q  <= '0;
      rsp_val_q <= '0;
      rsp_err_q <= 1'b0;
`ifdef FPADD_TIMEOUT_EN
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      gnt_q     <= gnt_d;
      add_n0_q  <= add_n0_d;
      add_n1_q  <= add_n1_d;
      rsp_val_q <= rsp_val_d;
      rsp_err_q <= rsp_err_d;
`ifdef FPADD_TIMEOUT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_RESP) rsp_valid[gnt_q] = 1'b1;
    case (state_q)
      S_ISSUE: leds = 4'b0010;
      S_WAIT:  leds = 4'b0100;
      S_RESP:  leds = 4'b1000;
      default: leds = 4'b0001;
    endcase
  end

  assign add_n0  = add_n0_q;
  assign add_n1  = add_n1_q;
  assign add_go  = (state_q == S_ISSUE);
  assign busy    = (state_q != S_IDLE);
  assign rsp_val = rsp_val_q;
  assign rsp_err = rsp_err_q;

endmodule
